countdown_timer_ctrl: RTL

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

---
 rtl/countdown_timer_if.sv | 28 ++
 rtl/countdown_timer_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Command/status bundle between the countdown controller, its host and the four
// BCD digit counters it sequences.
interface countdown_timer_if;
    logic        start;
    logic        pause;
    logic        abort;
    logic [15:0] preset;
    logic [3:0]  digit_tc;
    logic        cnt_ena;
    logic [3:0]  ena_cnt;
    logic [3:0]  load_n;
    logic [15:0] load_data;
    logic        running;
    logic        paused;
    logic        expired;
    logic        done;
    logic        err;

    modport master (
        output start, pause, abort, preset, digit_tc,
        input  cnt_ena, ena_cnt, load_n, load_data, running, paused, expired, done, err
    );

    modport slave (
        input  start, pause, abort, preset, digit_tc,
        output cnt_ena, ena_cnt, load_n, load_data, running, paused, expired, done, err
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown controller: loads four external BCD down-counters, paces them with
// a prescaled tick, handles pause/abort and flags expiry at 00:00.
module countdown_timer_ctrl #(
    parameter int unsigned CLKS_PER_TICK = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave tmr
);
    localparam int unsigned        PRESC_W   = $clog2(CLKS_PER_TICK);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKS_PER_TICK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_nxt;
    logic               tick;
    logic               tick_nxt;
    logic [15:0]        preset_q;
    logic               preset_ok;
    logic               start_ok;
    logic               all_tc;
    logic               run_step;

    // Event qualification; run_step is a tick that no higher-priority event overrides
    always_comb begin
        preset_ok = (tmr.preset[15:12] <= 4'd9) && (tmr.preset[11:8] <= 4'd9) &&
                    (tmr.preset[7:4]   <= 4'd5) && (tmr.preset[3:0]  <= 4'd9);
        all_tc    = &tmr.digit_tc;
        start_ok  = tmr.start && preset_ok && (state != S_LOAD) && (state != S_SETTLE);
        run_step  = (state == S_RUN) && tick && !all_tc && !tmr.pause &&
                    !tmr.abort && !start_ok;
    end

    // Next state, prescaler and tick
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        tick_nxt  = 1'b0;
        if (tmr.abort) begin
            state_nxt = S_IDLE;
            presc_nxt = '0;
        end else if (start_ok) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    state_nxt = S_SETTLE;
                    presc_nxt = '0;
                end
                S_SETTLE: state_nxt = all_tc ? S_EXPIRED : S_RUN;
                S_RUN: begin
                    if (all_tc) begin
                        state_nxt = S_EXPIRED;
                    end else if (tmr.pause) begin
                        state_nxt = S_PAUSE;
                    end else if (presc == PRESC_MAX) begin
                        presc_nxt = '0;
                        tick_nxt  = 1'b1;
                    end else begin
                        presc_nxt = presc + PRESC_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (!tmr.pause) state_nxt = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // Counter strobes; the second-tens borrow reloads 5 instead of wrapping to 9
    always_comb begin
        tmr.ena_cnt   = 4'b0000;
        tmr.load_n    = 4'b1111;
        tmr.load_data = 16'h0000;
        if (state == S_LOAD) begin
            tmr.load_n    = 4'b0000;
            tmr.load_data = preset_q;
        end else if (run_step) begin
            tmr.ena_cnt = {&tmr.digit_tc[2:0], &tmr.digit_tc[1:0], tmr.digit_tc[0], 1'b1};
            if (tmr.digit_tc[0] && tmr.digit_tc[1]) begin
                tmr.load_n[1]      = 1'b0;
                tmr.load_data[7:4] = 4'd5;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            presc       <= '0;
            tick        <= 1'b0;
            preset_q    <= 16'h0000;
            tmr.cnt_ena <= 1'b0;
            tmr.running <= 1'b0;
            tmr.paused  <= 1'b0;
            tmr.expired <= 1'b0;
            tmr.done    <= 1'b0;
            tmr.err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            tick        <= tick_nxt;
            if (start_ok && !tmr.abort) preset_q <= tmr.preset;
            tmr.cnt_ena <= (state_nxt == S_RUN);
            tmr.running <= (state_nxt == S_RUN);
            tmr.paused  <= (state_nxt == S_PAUSE);
            tmr.expired <= (state_nxt == S_EXPIRED);
            tmr.done    <= (state_nxt == S_EXPIRED) && (state != S_EXPIRED);
            tmr.err     <= tmr.start && !preset_ok && !tmr.abort;
        end
    end
endmodule
